range_stream_gen: RTL and testbench
===================================

Name: range_stream_gen

Overview:
- Burst transmitter for the go/finish sample-stream protocol consumed by the range-finder block.
- Emits one WIDTH-bit sample per cycle:
  - `go` is high with the first sample.
  - `finish` is high with the last sample.
- Burst content is built so the correct range (max - min) is known in advance and published on `expected_range`.
- Used as on-chip self-test stimulus and as the driver side of the same 12-bit chip I/O interface.

Parameters:
- WIDTH, 10, sample and range width
- LEN_W, 8, width of burst-length field (max burst 2^LEN_W - 1 samples)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state and outputs
- start  input  1  request a burst; sampled only in IDLE
- lo  input  WIDTH  burst minimum value
- hi  input  WIDTH  burst maximum value
- len  input  LEN_W  number of samples in burst
- step  input  WIDTH  ramp increment for interior samples
- data_out  output  WIDTH  current sample
- go  output  1  high with first sample only
- finish  output  1  high with last sample only
- busy  output  1  high while burst samples are being driven
- done  output  1  one-cycle pulse after last sample
- cfg_error  output  1  one-cycle pulse on rejected start
- expected_range  output  WIDTH  hi - lo of the last accepted burst

Behaviour:
- Reset values: all outputs 0, state IDLE, config registers 0.
- All outputs are registered.
- States:
  - IDLE:
    - start=1 and cfg valid: latch lo/hi/len/step; set expected_range = hi - lo; go to SEND.
    - start=1 and cfg invalid: pulse cfg_error next cycle; stay IDLE; expected_range unchanged.
    - cfg invalid means len==0 or hi<lo.
  - SEND: one sample per cycle, index k = 0..len-1.
    - After k = len-1, go to DONE.
  - DONE: done=1 for one cycle; busy=0; then IDLE.
- Latency:
  - go/first sample appear the cycle after start is accepted.
  - The burst occupies exactly len consecutive cycles.
  - done appears in the cycle immediately after finish.
- Sample sequence:
  - k=0: lo.
  - k=1: hi.
  - k>=2: ramp r. r starts at lo at k=2; r_next = r + step if (r + step) <= hi, else r_next = lo.
  - The ramp sum is computed in WIDTH+1 bits, so there is no wrap-around overflow.
  - Every sample lies in [lo, hi], and both extremes appear when len>=2.
- Boundaries:
  - len==1: single sample lo with go=1 and finish=1 in the same cycle; expected_range = hi - lo is still published, but the receiver sees range 0. The bench treats len==1 as a range-0 case.
  - lo==hi: all samples equal; expected_range 0.
  - step==0: interior samples all lo.
  - Max len: no counter wrap; the index counter is LEN_W bits, and the compare is against len-1.
- start while busy or in DONE: ignored, not queued.
- Inputs lo/hi/len/step may change freely after acceptance; only latched copies are used.
- go and finish are never high outside SEND.
- Reset mid-burst: next edge returns all outputs to 0. No finish or done is emitted for the aborted burst.
- When busy=0: data_out = 0.

Optional Feature:
- RANGE_GEN_REPEAT_EN
  - Defined: in DONE, if start is still high and cfg is valid, relatch cfg and begin a new burst after exactly one idle cycle (the done cycle). The new go arrives the cycle after done.
  - Undefined: start must be sampled in IDLE. A held start re-triggers only from IDLE, giving a minimum of 2 idle cycles between bursts.

Decomposition:
- Package range_pkg:
  - state enum {IDLE, SEND, DONE}
  - default WIDTH/LEN_W constants
  - cfg-valid check function
- Sub-module range_ramp_step (combinational): inputs r, step, lo, hi; output r_next. Keeps the WIDTH+1 compare isolated and unit-testable.

Test Plan:
- Basic burst: lo=100, hi=200, len=5, step=30, start pulse. Required response:
  - data_out = 100, 200, 100, 130, 160.
  - go on 100 only; finish on 160 only.
  - done the next cycle; expected_range = 100.
- Ramp wrap: lo=10, hi=20, len=7, step=6 -> samples 10, 20, 10, 16, 10, 16, 10.
- Config errors:
  - hi=5, lo=9, len=3 -> cfg_error pulse; no go; busy stays 0.
  - len=0 -> same response.
- len=1: lo=hi=42 -> single cycle with data_out=42 and go=finish=1; done next cycle; expected_range=0.
- Mid-burst reset: start (len=10), assert reset at k=4 -> all outputs 0 the next cycle; no finish; no done. A new start then works normally.
- Loopback: drive the range-finder with this block over 20 random valid configs with len>=2. The measured range must equal expected_range, with no debug_error. With RANGE_GEN_REPEAT_EN defined and start held high, bursts are spaced by exactly one done cycle.

Source files
------------

// File: rtl/range_stream_gen_pkg.sv
// ============================================================================
// Module : range_pkg
// Brief  : Shared types, default widths and the config check for range_stream_gen.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package range_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    // A burst needs at least one sample and a non-inverted range.
    function automatic logic cfg_valid(input logic [31:0] lo,
                                       input logic [31:0] hi,
                                       input logic [31:0] len);
        return (len != 32'd0) && (hi >= lo);
    endfunction

endpackage

`default_nettype wire

// File: rtl/range_stream_gen_if.sv
// ============================================================================
// Module : range_stream_gen_if
// Brief  : Config request plus go/finish sample-stream bundle of range_stream_gen.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface range_stream_gen_if #(
    parameter int WIDTH = 10,
    parameter int LEN_W = 8
) ();
    logic             start;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             done;
    logic             cfg_error;
    logic [WIDTH-1:0] expected_range;

    // master: the generator; slave: whoever configures it and consumes the stream
    modport master (
        input  start, lo, hi, len, step,
        output data_out, go, finish, busy, done, cfg_error, expected_range
    );

    modport slave (
        output start, lo, hi, len, step,
        input  data_out, go, finish, busy, done, cfg_error, expected_range
    );
endinterface

`default_nettype wire

// File: rtl/range_stream_gen_ramp_step.sv
// ============================================================================
// Module : range_ramp_step
// Brief  : Next ramp value; advances by step, falls back to lo once past hi.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module range_ramp_step #(
    parameter int WIDTH = 10
) (
    input  wire logic [WIDTH-1:0] r,
    input  wire logic [WIDTH-1:0] step,
    input  wire logic [WIDTH-1:0] lo,
    input  wire logic [WIDTH-1:0] hi,
    output      logic [WIDTH-1:0] r_next
);

    // One extra bit so a large step can never wrap back into [lo, hi].
    logic [WIDTH:0] w_sum;

    assign w_sum  = {1'b0, r} + {1'b0, step};
    assign r_next = (w_sum <= {1'b0, hi}) ? w_sum[WIDTH-1:0] : lo;

endmodule

`default_nettype wire

// File: rtl/range_stream_gen.sv
// ============================================================================
// Module : range_stream_gen
// Brief  : go/finish burst generator with a known-in-advance range (hi - lo).
//          Define RANGE_GEN_REPEAT_EN to re-arm directly from DONE on held start.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module range_stream_gen
    import range_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  wire logic          clock,
    input  wire logic          reset,
    range_stream_gen_if.master bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [LEN_W-1:0] r_len;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_ramp;
    logic [LEN_W-1:0] r_idx;
    logic [WIDTH-1:0] r_data;
    logic             r_go;
    logic             r_finish;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_error;
    logic [WIDTH-1:0] r_range;

    logic             w_cfg_ok;
    logic             w_can_start;
    logic             w_accept;
    logic [LEN_W-1:0] w_last;
    logic [LEN_W-1:0] w_idx_next;
    logic [WIDTH-1:0] w_ramp_next;

    assign w_cfg_ok = cfg_valid(32'(bus.lo), 32'(bus.hi), 32'(bus.len));

`ifdef RANGE_GEN_REPEAT_EN
    assign w_can_start = (r_state == IDLE) || (r_state == DONE);
`else
    assign w_can_start = (r_state == IDLE);
`endif

    assign w_accept   = bus.start && w_cfg_ok && w_can_start;
    assign w_last     = r_len - LEN_W'(1);
    assign w_idx_next = r_idx + LEN_W'(1);

    range_ramp_step #(.WIDTH(WIDTH)) u_ramp (
        .r      (r_ramp),
        .step   (r_step),
        .lo     (r_lo),
        .hi     (r_hi),
        .r_next (w_ramp_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_len       <= '0;
            r_step      <= '0;
            r_ramp      <= '0;
            r_idx       <= '0;
            r_data      <= '0;
            r_go        <= 1'b0;
            r_finish    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_error <= 1'b0;
            r_range     <= '0;
        end else begin
            r_cfg_error <= 1'b0;
            if (w_accept) begin
                // Sample k=0 (lo) is presented the cycle after acceptance.
                r_state  <= SEND;
                r_lo     <= bus.lo;
                r_hi     <= bus.hi;
                r_len    <= bus.len;
                r_step   <= bus.step;
                r_range  <= bus.hi - bus.lo;
                r_ramp   <= bus.lo;
                r_idx    <= '0;
                r_data   <= bus.lo;
                r_go     <= 1'b1;
                r_finish <= (bus.len == LEN_W'(1));
                r_busy   <= 1'b1;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_cfg_error <= 1'b1;
                        end
                    end
                    SEND: begin
                        r_go <= 1'b0;
                        if (r_idx == w_last) begin
                            r_state  <= DONE;
                            r_data   <= '0;
                            r_finish <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx    <= w_idx_next;
                            r_finish <= (w_idx_next == w_last);
                            if (r_idx == '0) begin
                                r_data <= r_hi;
                            end else begin
                                r_data <= r_ramp;
                                r_ramp <= w_ramp_next;
                            end
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.data_out       = r_data;
    assign bus.go             = r_go;
    assign bus.finish         = r_finish;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.cfg_error      = r_cfg_error;
    assign bus.expected_range = r_range;

endmodule

`default_nettype wire

// File: tb/tb_range_stream_gen.sv
// ============================================================================
// Module : tb_range_stream_gen
// Brief  : Scoreboard bench for range_stream_gen; RANGE_GEN_REPEAT_EN selects
//          the expected spacing between back-to-back bursts on held start.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_range_stream_gen;

    localparam int WIDTH = 10;
    localparam int LEN_W = 8;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef RANGE_GEN_REPEAT_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 2;
`endif

    typedef struct {
        int data;
        bit go;
        bit fin;
        int rng;
        int rcv;
    } sample_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    range_stream_gen_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

    range_stream_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    sample_t exp_q[$];
    int      gap_q[$];
    int      checks     = 0;
    int      errors     = 0;
    bit      pend_done  = 1'b0;
    bit      have_fin   = 1'b0;
    int      gap_cnt    = 0;
    int      go_count   = 0;
    int      bmin       = 0;
    int      bmax       = 0;
    int      last_range = 0;
    sample_t mon_s;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference burst: lo, hi, then a ramp from lo that restarts at lo past hi.
    function automatic void push_burst(input int lo, input int hi, input int len, input int step);
        int r = lo;
        for (int k = 0; k < len; k++) begin
            sample_t s;
            s.go  = (k == 0);
            s.fin = (k == len - 1);
            s.rng = hi - lo;
            s.rcv = (len >= 2) ? hi - lo : 0;
            if (k == 0)      s.data = lo;
            else if (k == 1) s.data = hi;
            else begin
                s.data = r;
                r = (r + step <= hi) ? r + step : lo;
            end
            exp_q.push_back(s);
        end
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            if (!bus.busy) begin
                check("idle_go_finish", int'({bus.go, bus.finish}), 0);
                check("idle_data", int'(bus.data_out), 0);
                check("done", int'(bus.done), int'(pend_done));
                pend_done = 1'b0;
                gap_cnt++;
            end else if (exp_q.size() == 0) begin
                check("unexpected_sample_busy", int'(bus.busy), 0);
            end else begin
                mon_s = exp_q.pop_front();
                check("data_out", int'(bus.data_out), mon_s.data);
                check("go", int'(bus.go), int'(mon_s.go));
                check("finish", int'(bus.finish), int'(mon_s.fin));
                check("done_while_busy", int'(bus.done), 0);
                if (bus.go) begin
                    go_count++;
                    if (have_fin) gap_q.push_back(gap_cnt);
                    bmin = int'(bus.data_out);
                    bmax = int'(bus.data_out);
                end else begin
                    if (int'(bus.data_out) < bmin) bmin = int'(bus.data_out);
                    if (int'(bus.data_out) > bmax) bmax = int'(bus.data_out);
                end
                if (bus.finish) begin
                    check("expected_range", int'(bus.expected_range), mon_s.rng);
                    check("loopback_range", bmax - bmin, mon_s.rcv);
                    pend_done = 1'b1;
                    have_fin  = 1'b1;
                    gap_cnt   = 0;
                end
            end
        end
    end

    task automatic issue(input int lo, input int hi, input int len, input int step);
        @(posedge clock);
        #1;
        bus.lo    = WIDTH'(lo);
        bus.hi    = WIDTH'(hi);
        bus.len   = LEN_W'(len);
        bus.step  = WIDTH'(step);
        bus.start = 1'b1;
        if (len != 0 && hi >= lo) begin
            push_burst(lo, hi, len, step);
            last_range = hi - lo;
        end
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.lo    = WIDTH'($urandom);
        bus.hi    = WIDTH'($urandom);
        bus.len   = LEN_W'($urandom);
        bus.step  = WIDTH'($urandom);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 600; i++) begin
            @(posedge clock);
            if (exp_q.size() == 0 && !pend_done) break;
        end
        if (i == 600) check("drain_timeout_pending", exp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_err(input int lo, input int hi, input int len);
        issue(lo, hi, len, 1);
        @(negedge clock);
        check("cfg_error_pulse", int'(bus.cfg_error), 1);
        check("cfg_error_busy", int'(bus.busy), 0);
        check("cfg_error_range_kept", int'(bus.expected_range), last_range);
        @(negedge clock);
        check("cfg_error_one_cycle", int'(bus.cfg_error), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, int'(bus.data_out), 0);
        check({tag, "_go"}, int'(bus.go), 0);
        check({tag, "_finish"}, int'(bus.finish), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_cfg_error"}, int'(bus.cfg_error), 0);
        check({tag, "_range"}, int'(bus.expected_range), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, hi, len, step, base, i;
        bus.start = 1'b0;
        bus.lo    = '0;
        bus.hi    = '0;
        bus.len   = '0;
        bus.step  = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("reset");

        issue(100, 200, 5, 30);
        drain();
        issue(10, 20, 7, 6);
        drain();
        cfg_err(9, 5, 3);
        cfg_err(1, 2, 0);
        issue(42, 42, 1, 7);
        drain();
        issue(77, 77, 5, 3);
        drain();
        issue(5, 900, 6, 0);
        drain();
        issue(0, MAXV, 8, 1000);
        drain();
        issue(0, MAXV, 255, 37);
        drain();

        // Mid-burst reset at sample k=4: stream aborts with no finish or done.
        issue(50, 500, 10, 77);
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        exp_q.delete();
        pend_done = 1'b0;
        have_fin  = 1'b0;
        last_range = 0;
        @(negedge clock);
        check_all_zero("mid_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("after_reset");
        issue(100, 200, 5, 30);
        drain();

        // Held start: three bursts of the same config, spacing depends on build.
        gap_q.delete();
        have_fin = 1'b0;
        base = go_count;
        repeat (3) push_burst(300, 400, 4, 50);
        last_range = 100;
        @(posedge clock);
        #1;
        bus.lo    = WIDTH'(300);
        bus.hi    = WIDTH'(400);
        bus.len   = LEN_W'(4);
        bus.step  = WIDTH'(50);
        bus.start = 1'b1;
        for (i = 0; i < 200; i++) begin
            @(posedge clock);
            if (go_count >= base + 3) break;
        end
        if (i == 200) check("held_start_go_count", go_count - base, 3);
        #1;
        bus.start = 1'b0;
        drain();
        check("held_start_gaps", gap_q.size(), 2);
        for (int g = 0; g < gap_q.size(); g++) check("held_start_gap", gap_q[g], EXP_GAP);

        for (int n = 0; n < 20; n++) begin
            lo   = int'($urandom_range(MAXV, 0));
            hi   = int'($urandom_range(MAXV, lo));
            len  = int'($urandom_range(12, 2));
            step = int'($urandom_range(300, 0));
            issue(lo, hi, len, step);
            drain();
        end
        for (int n = 0; n < 4; n++) begin
            lo = int'($urandom_range(MAXV, 1));
            cfg_err(lo, int'($urandom_range(lo - 1, 0)), int'($urandom_range(12, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
